// File: rtl/chain_latency_meter.sv
// Step-launch latency meter for a register delay chain: flushes the chain, drives a step, counts edges to its arrival.
// Optional CHAIN_LATENCY_METER_CONTINUOUS_EN: auto re-run after each report, plus run_count / any_fail outputs.
module chain_latency_meter #(
    parameter int unsigned N_EXPECTED   = 256,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FLUSH_CYCLES = 300,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             chain_out,
    output logic             chain_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] latency,
    output logic             pass,
    output logic             timeout,
    output logic [7:0]       leds
`ifdef CHAIN_LATENCY_METER_CONTINUOUS_EN
    ,
    output logic [15:0]      run_count,
    output logic             any_fail
`endif
);

    // The total-flush counter must hold FLUSH_CYCLES + TIMEOUT, so it gets one extra bit.
    localparam int unsigned TOT_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] FLUSH_TARGET = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] EXPECTED     = CNT_W'(N_EXPECTED);
    localparam logic [TOT_W-1:0] FLUSH_LIMIT  = TOT_W'(FLUSH_CYCLES + TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [TOT_W-1:0] TOT_ONE      = TOT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        MEASURE,
        REPORT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] flush_cnt, flush_next;
    logic [TOT_W-1:0] total, total_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             chain_in_next;
    logic [CNT_W-1:0] latency_next;
    logic             pass_next;
    logic             timeout_next;
    logic             done_next;
    logic             launch;

`ifdef CHAIN_LATENCY_METER_CONTINUOUS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
            total     <= '0;
            cnt       <= '0;
            chain_in  <= 1'b0;
            latency   <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_next;
            total     <= total_next;
            cnt       <= cnt_next;
            chain_in  <= chain_in_next;
            latency   <= latency_next;
            pass      <= pass_next;
            timeout   <= timeout_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        flush_next    = flush_cnt;
        total_next    = total;
        cnt_next      = cnt;
        chain_in_next = chain_in;
        latency_next  = latency;
        pass_next     = pass;
        timeout_next  = timeout;
        done_next     = 1'b0;
        launch        = 1'b0;

        unique case (state)
            IDLE: begin
                chain_in_next = 1'b0;
                launch        = start;
            end

            FLUSH: begin
                chain_in_next = 1'b0;
                total_next    = total + TOT_ONE;
                flush_next    = chain_out ? '0 : flush_cnt + CNT_ONE;
                // A completed flush wins over the flush timeout on the same edge.
                if (!chain_out && (flush_cnt + CNT_ONE == FLUSH_TARGET)) begin
                    state_next    = MEASURE;
                    chain_in_next = 1'b1;
                    cnt_next      = '0;
                end else if (total == FLUSH_LIMIT) begin
                    state_next   = REPORT;
                    latency_next = '1;
                    timeout_next = 1'b1;
                    pass_next    = 1'b0;
                    done_next    = 1'b1;
                end
            end

            MEASURE: begin
                chain_in_next = 1'b1;
                if (chain_out) begin
                    state_next    = REPORT;
                    chain_in_next = 1'b0;
                    latency_next  = cnt;
                    timeout_next  = 1'b0;
                    pass_next     = (cnt == EXPECTED);
                    done_next     = 1'b1;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_next    = REPORT;
                    chain_in_next = 1'b0;
                    latency_next  = cnt;
                    timeout_next  = 1'b1;
                    pass_next     = 1'b0;
                    done_next     = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            REPORT: begin
                chain_in_next = 1'b0;
`ifdef CHAIN_LATENCY_METER_CONTINUOUS_EN
                launch        = start || done;
`else
                launch        = start;
`endif
            end
        endcase

        if (launch) begin
            state_next   = FLUSH;
            flush_next   = '0;
            total_next   = '0;
            cnt_next     = '0;
            pass_next    = 1'b0;
            timeout_next = 1'b0;
        end
    end

`ifdef CHAIN_LATENCY_METER_CONTINUOUS_EN
    // pass is still the finished run's verdict during the done cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_count <= '0;
            any_fail  <= 1'b0;
        end else if (done) begin
            run_count <= sat_inc16(run_count);
            if (!pass) begin
                any_fail <= 1'b1;
            end
        end
    end
`endif

    assign busy = (state == FLUSH) || (state == MEASURE);
    assign leds = latency[7:0];

endmodule

// File: tb/tb_chain_latency_meter.sv
// Randomized bench for chain_latency_meter with a behavioural delay chain and a done-driven scoreboard.
module tb_chain_latency_meter;

    localparam int N_EXP  = 256;
    localparam int CNT_W  = 16;
    localparam int FLUSH  = 300;
    localparam int TMO    = 1023;
    localparam int STUCK0 = -1;
    localparam int STUCK1 = -2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              chain_out;
    logic              chain_in;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  latency;
    logic              pass;
    logic              timeout;
    logic [7:0]        leds;

    chain_latency_meter #(
        .N_EXPECTED  (N_EXP),
        .CNT_W       (CNT_W),
        .FLUSH_CYCLES(FLUSH),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .chain_out(chain_out),
        .chain_in (chain_in),
        .busy     (busy),
        .done     (done),
        .latency  (latency),
        .pass     (pass),
        .timeout  (timeout),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    // Behavioural chain: depth 0 is a wire, depth K taps the K-th register, negative depths are stuck lines.
    int       depth = 0;
    bit       chain_clr = 1'b0;
    bit [511:0] sr;

    always @(posedge clk) begin
        if (chain_clr) sr <= '0;
        else           sr <= {sr[510:0], chain_in};
    end

    always_comb begin
        chain_out = 1'b0;
        if (depth == STUCK1)      chain_out = 1'b1;
        else if (depth == STUCK0) chain_out = 1'b0;
        else if (depth == 0)      chain_out = chain_in;
        else                      chain_out = sr[9'(depth - 1)];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] lat;
        logic        pass;
        logic        to;
        int          dur;
        int          scyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected outcome of one run on a freshly cleared chain.
    function automatic exp_t predict(input int d, input int scyc);
        exp_t e;
        e.scyc = scyc;
        if (d == STUCK1) begin
            e.lat = 16'hFFFF; e.to = 1'b1; e.pass = 1'b0; e.dur = FLUSH + TMO + 1;
        end else if (d == STUCK0 || d > TMO) begin
            e.lat = 16'(TMO); e.to = 1'b1; e.pass = 1'b0; e.dur = FLUSH + TMO + 1;
        end else begin
            e.lat = 16'(d); e.to = 1'b0; e.pass = (d == N_EXP); e.dur = FLUSH + d + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            check("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("latency",        latency, mon_e.lat);
                check("leds",           leds, mon_e.lat[7:0]);
                check("pass",           pass, mon_e.pass);
                check("timeout",        timeout, mon_e.to);
                check("done_cycles",    cyc - mon_e.scyc, mon_e.dur);
                check("busy_at_done",   busy, 0);
                check("chain_in_done",  chain_in, 0);
            end
        end
        if (prev_done) check("done_one_cycle", done, 0);
        prev_done <= done;
    end

    task automatic prepare(input int d);
        @(negedge clk);
        depth     = d;
        chain_clr = 1'b1;
        @(negedge clk);
        chain_clr = 1'b0;
    endtask

    task automatic run(input int d, input int extra_at);
        int nb = 0;
        int ci = 0;
        bit got = 1'b0;
        prepare(d);
        start = 1'b1;
        sb.push_back(predict(d, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        check("pass_cleared", pass, 0);
        check("timeout_cleared", timeout, 0);
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            start = (i == extra_at);
            if (!busy)    nb++;
            if (chain_in) ci++;
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("busy_during_run", nb, 0);
        if (d == STUCK1) check("chain_in_never_high", ci, 0);
        @(negedge clk);
        check("chain_in_after_done", chain_in, 0);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_cleared();
        check("rst_chain_in", chain_in, 0);
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_latency",  latency, 0);
        check("rst_pass",     pass, 0);
        check("rst_timeout",  timeout, 0);
        check("rst_leds",     leds, 0);
    endtask

    initial begin
        int r;
        int d;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared();
        rst_n = 1'b1;

        run(0, -1);
        run(N_EXP, -1);
        run(5, -1);
        run(STUCK0, -1);
        run(STUCK1, -1);

        for (int k = 0; k < 10; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       d = int'($urandom_range(1, FLUSH));
            else if (r == 7) d = STUCK0;
            else if (r == 8) d = N_EXP;
            else             d = 0;
            run(d, -1);
        end

        // Reset in the middle of MEASURE, at cnt = 100.
        prepare(200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (FLUSH + 100) @(negedge clk);
        check("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared();
        @(negedge clk);
        check("idle_after_reset", busy, 0);

        // Fresh run with a stray start pulse during FLUSH.
        run(7, 50);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired actual=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
